fetch_pc_ctrl: RTL and testbench

//   Owns the program counter and drives instruction fetch. It turns the next-PC decision
//   (PCSrc/PCTarget redirect, else PC+4) into a request/grant/response fetch transaction.
//   It then presents the fetched word to decode over a valid/ready handshake.

---
 rtl/fetch_pc_ctrl_pkg.sv | 12 +
 rtl/fetch_pc_ctrl_timeout_ctr.sv | 31 +++
 rtl/fetch_pc_ctrl.sv | 141 ++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared definitions for the fetch PC controller: FSM state codes and defaults.
package fetch_pc_ctrl_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
   localparam int          CNT_W        = 8;

endpackage

// File: rtl/fetch_pc_ctrl_timeout_ctr.sv
// Saturating WAIT-cycle counter; hit flags when the count equals LIMIT.
module fetch_timeout_ctr
   import fetch_pc_ctrl_pkg::*;
#(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic hit
);

   logic [CNT_W-1:0] cnt;

   // count enabled cycles, stick at all-ones, clear on request
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + CNT_W'(1);
   end

   // limit comparison
   always_comb begin
      hit = (cnt == CNT_W'(LIMIT));
   end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Program counter owner: issues one fetch at a time and hands the word to decode.
module fetch_pc_ctrl
   import fetch_pc_ctrl_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = XLEN'(DEF_RESET_PC),
   parameter int              TIMEOUT_CYC = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_en,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_pc_plus4,
   output logic            misalign_err,
   output logic            fetch_timeout
);

   logic [1:0]      state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic            kill, kill_nxt;
   logic            capture;
   logic            timeout_evt;
   logic            redir;
   logic [XLEN-1:0] redir_tgt;
   logic            to_hit;
   logic            cnt_clr;
   logic            cnt_en;

   // redirects are only honoured once the fetch machine is running
   assign redir     = redirect_en && (state != ST_IDLE);
   assign redir_tgt = {redirect_pc[XLEN-1:2], 2'b00};

   // counter clears on the grant that enters WAIT and runs while waiting
   assign cnt_clr = (state == ST_REQ) && imem_gnt;
   assign cnt_en  = (state == ST_WAIT);

   fetch_timeout_ctr #(.LIMIT(TIMEOUT_CYC)) u_tmo (
      .clk    (clk),
      .reset  (reset),
      .clear  (cnt_clr),
      .enable (cnt_en),
      .hit    (to_hit)
   );

   // state register
   always_ff @(posedge clk) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // next state plus pc/kill updates; a redirect overrides every other event
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      kill_nxt    = kill;
      capture     = 1'b0;
      timeout_evt = 1'b0;
      case (state)
         ST_IDLE: state_nxt = ST_REQ;
         ST_REQ: begin
            // a grant racing a redirect still owes us a response; mark it stale
            if (imem_gnt) begin
               state_nxt = ST_WAIT;
               kill_nxt  = redir;
            end
         end
         ST_WAIT: begin
            if (redir) begin
               if (imem_rvalid)
                  state_nxt = ST_REQ;
               else
                  kill_nxt = 1'b1;
            end else if (imem_rvalid) begin
               if (kill) begin
                  state_nxt = ST_REQ;
               end else begin
                  state_nxt = ST_HOLD;
                  capture   = 1'b1;
               end
            end else if (to_hit) begin
               state_nxt   = ST_REQ;
               timeout_evt = 1'b1;
            end
         end
         ST_HOLD: begin
            if (redir) begin
               state_nxt = ST_REQ;
            end else if (inst_ready) begin
               state_nxt = ST_REQ;
               pc_nxt    = pc + XLEN'(4);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (redir)
         pc_nxt = redir_tgt;
   end

   // handshake outputs decoded from state
   always_comb begin
      imem_req   = (state == ST_REQ);
      inst_valid = (state == ST_HOLD);
   end

   assign imem_addr = pc;

   // pc, kill flag, holding registers and one-cycle event pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         pc            <= RESET_PC;
         kill          <= 1'b0;
         inst_data     <= '0;
         inst_pc       <= '0;
         inst_pc_plus4 <= '0;
         misalign_err  <= 1'b0;
         fetch_timeout <= 1'b0;
      end else begin
         pc            <= pc_nxt;
         kill          <= kill_nxt;
         misalign_err  <= redir && (redirect_pc[1:0] != 2'b00);
         fetch_timeout <= timeout_evt;
         if (capture) begin
            inst_data     <= imem_rdata;
            inst_pc       <= pc;
            inst_pc_plus4 <= pc + XLEN'(4);
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench: three instances share stimulus (default, short timeout, top-of-memory reset PC).
module tb_fetch_pc_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        inst_ready;

   logic        req  [3];
   logic        ival [3];
   logic        mis  [3];
   logic        tmo  [3];
   logic [31:0] addr [3];
   logic [31:0] idata[3];
   logic [31:0] ipc  [3];
   logic [31:0] ip4  [3];

   int vectors     = 0;
   int miscompares = 0;
   int n;

   always #5 clk = ~clk;

   fetch_pc_ctrl u_d0 (
      .clk(clk), .reset(reset), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .imem_req(req[0]), .imem_addr(addr[0]), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .inst_valid(ival[0]), .inst_ready(inst_ready),
      .inst_data(idata[0]), .inst_pc(ipc[0]), .inst_pc_plus4(ip4[0]),
      .misalign_err(mis[0]), .fetch_timeout(tmo[0])
   );

   fetch_pc_ctrl #(.TIMEOUT_CYC(4)) u_d1 (
      .clk(clk), .reset(reset), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .imem_req(req[1]), .imem_addr(addr[1]), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .inst_valid(ival[1]), .inst_ready(inst_ready),
      .inst_data(idata[1]), .inst_pc(ipc[1]), .inst_pc_plus4(ip4[1]),
      .misalign_err(mis[1]), .fetch_timeout(tmo[1])
   );

   fetch_pc_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_d2 (
      .clk(clk), .reset(reset), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
      .imem_req(req[2]), .imem_addr(addr[2]), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .inst_valid(ival[2]), .inst_ready(inst_ready),
      .inst_data(idata[2]), .inst_pc(ipc[2]), .inst_pc_plus4(ip4[2]),
      .misalign_err(mis[2]), .fetch_timeout(tmo[2])
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // REQ -> grant -> response next cycle -> HOLD
   task automatic fetch(input logic [31:0] d);
      imem_gnt = 1'b1;
      tick;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = d;
      tick;
      imem_rvalid = 1'b0;
   endtask

   task automatic accept;
      inst_ready = 1'b1;
      tick;
      inst_ready = 1'b0;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      tick;
   endtask

   initial begin
      reset = 1'b1; redirect_en = 1'b0; redirect_pc = '0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
      tick; tick;

      // reset state
      chk("rst_req",   32'(req[0]),  32'd0);
      chk("rst_addr",  addr[0],      32'h0);
      chk("rst_ival",  32'(ival[0]), 32'd0);
      chk("rst_idata", idata[0],     32'h0);
      chk("rst_ipc",   ipc[0],       32'h0);
      chk("rst_ip4",   ip4[0],       32'h0);
      chk("rst_mis",   32'(mis[0]),  32'd0);
      chk("rst_tmo",   32'(tmo[0]),  32'd0);
      chk("rst_addr2", addr[2],      32'hFFFF_FFFC);

      // first fetch
      reset = 1'b0;
      tick;
      chk("t1_req",  32'(req[0]), 32'd1);
      chk("t1_addr", addr[0],     32'h0);
      fetch(32'h0050_0093);
      chk("t1_ival",  32'(ival[0]), 32'd1);
      chk("t1_idata", idata[0],     32'h0050_0093);
      chk("t1_ipc",   ipc[0],       32'h0);
      chk("t1_ip4",   ip4[0],       32'h4);
      accept;
      chk("t1_next_req",  32'(req[0]),  32'd1);
      chk("t1_next_addr", addr[0],      32'h4);
      chk("t1_next_ival", 32'(ival[0]), 32'd0);

      // advance to pc 0x10, then redirect in HOLD with inst_ready high
      for (int i = 0; i < 3; i++) begin
         fetch(32'h0000_0013);
         accept;
      end
      fetch(32'h0000_0013);
      chk("t2_ipc", ipc[0], 32'h10);
      redirect_en = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b1;
      tick;
      redirect_en = 1'b0; inst_ready = 1'b0;
      chk("t2_ival", 32'(ival[0]), 32'd0);
      chk("t2_req",  32'(req[0]),  32'd1);
      chk("t2_addr", addr[0],      32'h200);

      // redirect during WAIT, stale response dropped
      do_reset;
      fetch(32'h0000_0013); accept;
      fetch(32'h0000_0013); accept;
      chk("t3_addr8", addr[0], 32'h8);
      imem_gnt = 1'b1;
      tick;
      imem_gnt = 1'b0;
      redirect_en = 1'b1; redirect_pc = 32'h80;
      tick;
      redirect_en = 1'b0;
      chk("t3_wait_req", 32'(req[0]), 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick;
      imem_rvalid = 1'b0;
      chk("t3_ival", 32'(ival[0]), 32'd0);
      chk("t3_req",  32'(req[0]),  32'd1);
      chk("t3_addr", addr[0],      32'h80);
      tick;
      chk("t3_ival2", 32'(ival[0]), 32'd0);

      // timeout with TIMEOUT_CYC=4: WAIT with cnt 0..4, leave when cnt hits 4
      do_reset;
      imem_gnt = 1'b1;
      tick;
      imem_gnt = 1'b0;
      n = 0;
      while (!tmo[1] && n < 20) begin
         tick;
         n++;
      end
      chk("t4_cycles", 32'(n),      32'd5);
      chk("t4_tmo",    32'(tmo[1]), 32'd1);
      chk("t4_req",    32'(req[1]), 32'd1);
      chk("t4_addr",   addr[1],     32'h0);
      tick;
      chk("t4_tmo_off", 32'(tmo[1]), 32'd0);

      // wrap at top of address space
      reset = 1'b1;
      tick;
      chk("t5_rst_addr", addr[2], 32'hFFFF_FFFC);
      reset = 1'b0;
      tick;
      fetch(32'h0000_0013);
      chk("t5_ival", 32'(ival[2]), 32'd1);
      chk("t5_ipc",  ipc[2],       32'hFFFF_FFFC);
      chk("t5_ip4",  ip4[2],       32'h0);
      accept;
      chk("t5_addr", addr[2], 32'h0);

      // misaligned redirect from REQ
      redirect_en = 1'b1; redirect_pc = 32'h102;
      tick;
      redirect_en = 1'b0;
      chk("t6_mis",  32'(mis[0]), 32'd1);
      chk("t6_addr", addr[0],     32'h100);
      chk("t6_req",  32'(req[0]), 32'd1);
      tick;
      chk("t6_mis_off", 32'(mis[0]), 32'd0);

      // reset mid-WAIT, late response ignored
      imem_gnt = 1'b1;
      tick;
      imem_gnt = 1'b0;
      chk("t7_wait_req", 32'(req[0]), 32'd0);
      reset = 1'b1;
      tick;
      reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_1234;
      tick;
      imem_rvalid = 1'b0;
      chk("t7_ival", 32'(ival[0]), 32'd0);
      chk("t7_req",  32'(req[0]),  32'd1);
      chk("t7_addr", addr[0],      32'h0);
      tick;
      chk("t7_ival2", 32'(ival[0]), 32'd0);
      chk("t7_addr2", addr[0],      32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
